// File: rtl/secuenciador_medicion.sv
// Measurement sequencer: shared ocle sample tick, settle + counting window, valid/ready result hand-off.
// Optional abort-on-restart in ESPERA/MIDIENDO enabled by defining SECUENCIADOR_ABORTO_EN.
module secuenciador_medicion #(
    parameter int unsigned DIV_CLE       = 50000,
    parameter int unsigned ESPERA_TICKS  = 20,
    parameter int unsigned VENTANA_TICKS = 1000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             ipulso_inicio,
    input  logic             ipulso_sensor,
    input  logic             ilisto_tx,
    output logic             ocle,
    output logic [CNT_W-1:0] ocuenta,
    output logic             ovalido,
    output logic             omidiendo,
    output logic             oocupado
);

    localparam int unsigned DIV_W     = (DIV_CLE > 2) ? $clog2(DIV_CLE) : 1;
    localparam int unsigned MAX_TICKS = (ESPERA_TICKS > VENTANA_TICKS) ? ESPERA_TICKS : VENTANA_TICKS;
    localparam int unsigned TICK_W    = $clog2(MAX_TICKS + 1);

    localparam logic [DIV_W-1:0]  DIV_ULT     = DIV_W'(DIV_CLE - 1);
    localparam logic [TICK_W-1:0] ESPERA_ULT  = TICK_W'(ESPERA_TICKS - 1);
    localparam logic [TICK_W-1:0] VENTANA_ULT = TICK_W'(VENTANA_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        ESPERA   = 2'd1,
        MIDIENDO = 2'd2,
        ENTREGA  = 2'd3
    } estado_t;

    estado_t            estado;
    estado_t            estado_sig;
    logic [DIV_W-1:0]   div_q;
    logic [TICK_W-1:0]  tick_q;
    logic [TICK_W-1:0]  tick_d;
    logic [CNT_W-1:0]   pulsos_q;
    logic [CNT_W-1:0]   pulsos_d;
    logic [CNT_W-1:0]   ocuenta_d;
    logic               ovalido_d;
    logic               omidiendo_d;
    logic               oocupado_d;
    logic               aborto;

`ifdef SECUENCIADOR_ABORTO_EN
    assign aborto = ipulso_inicio;
`else
    assign aborto = 1'b0;
`endif

    // Free-running tick divider; ocle is independent of the FSM
    always_ff @(posedge iclk) begin
        if (ireset) begin
            div_q <= '0;
            ocle  <= 1'b0;
        end else begin
            ocle  <= (div_q == DIV_ULT);
            div_q <= (div_q == DIV_ULT) ? '0 : div_q + DIV_W'(1);
        end
    end

    // State register plus tick and pulse counters
    always_ff @(posedge iclk) begin
        if (ireset) begin
            estado   <= REPOSO;
            tick_q   <= '0;
            pulsos_q <= '0;
        end else begin
            estado   <= estado_sig;
            tick_q   <= tick_d;
            pulsos_q <= pulsos_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        estado_sig = estado;
        tick_d     = tick_q;
        pulsos_d   = pulsos_q;
        case (estado)
            REPOSO: begin
                if (ipulso_inicio) begin
                    estado_sig = ESPERA;
                    tick_d     = '0;
                    pulsos_d   = '0;
                end
            end
            ESPERA: begin
                if (aborto) begin
                    estado_sig = REPOSO;
                    tick_d     = '0;
                    pulsos_d   = '0;
                end else if (ocle) begin
                    if (tick_q == ESPERA_ULT) begin
                        estado_sig = MIDIENDO;
                        tick_d     = '0;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            MIDIENDO: begin
                if (aborto) begin
                    estado_sig = REPOSO;
                    tick_d     = '0;
                    pulsos_d   = '0;
                end else begin
                    // Saturating count; a pulse on the final tick still counts
                    if (ipulso_sensor && (pulsos_q != CNT_MAX)) begin
                        pulsos_d = pulsos_q + CNT_W'(1);
                    end
                    if (ocle) begin
                        if (tick_q == VENTANA_ULT) begin
                            estado_sig = ENTREGA;
                            tick_d     = '0;
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                end
            end
            ENTREGA: begin
                if (ovalido && ilisto_tx) begin
                    estado_sig = REPOSO;
                end
            end
            default: begin
                estado_sig = REPOSO;
            end
        endcase
    end

    // Output next values, derived from the upcoming state so outputs align with it
    always_comb begin
        ocuenta_d   = ocuenta;
        ovalido_d   = (estado_sig == ENTREGA);
        omidiendo_d = (estado_sig == MIDIENDO);
        oocupado_d  = (estado_sig != REPOSO);
        if ((estado == REPOSO) && (estado_sig == ESPERA)) begin
            ocuenta_d = '0;
        end else if (aborto && ((estado == ESPERA) || (estado == MIDIENDO))) begin
            ocuenta_d = '0;
        end else if ((estado == MIDIENDO) && (estado_sig == ENTREGA)) begin
            ocuenta_d = pulsos_d;
        end
    end

    // Registered outputs
    always_ff @(posedge iclk) begin
        if (ireset) begin
            ocuenta   <= '0;
            ovalido   <= 1'b0;
            omidiendo <= 1'b0;
            oocupado  <= 1'b0;
        end else begin
            ocuenta   <= ocuenta_d;
            ovalido   <= ovalido_d;
            omidiendo <= omidiendo_d;
            oocupado  <= oocupado_d;
        end
    end

endmodule

// File: tb/tb_secuenciador_medicion.sv
// Self-checking bench for secuenciador_medicion: per-cycle reference model plus directed scenarios.
module tb_secuenciador_medicion;

    localparam int unsigned DIV  = 4;
    localparam int unsigned ESP  = 2;
    localparam int unsigned VEN  = 8;
    localparam int unsigned W    = 4;
    localparam int          MAXC = (1 << W) - 1;

    localparam int F_REPOSO   = 0;
    localparam int F_ESPERA   = 1;
    localparam int F_MIDIENDO = 2;
    localparam int F_ENTREGA  = 3;

`ifdef SECUENCIADOR_ABORTO_EN
    localparam bit ABORTO = 1'b1;
`else
    localparam bit ABORTO = 1'b0;
`endif

    logic         iclk          = 1'b0;
    logic         ireset        = 1'b1;
    logic         ipulso_inicio = 1'b0;
    logic         ipulso_sensor = 1'b0;
    logic         ilisto_tx     = 1'b0;
    logic         ocle;
    logic [W-1:0] ocuenta;
    logic         ovalido;
    logic         omidiendo;
    logic         oocupado;

    int checks = 0;
    int errors = 0;
    int ciclo  = 0;

    // Reference model state
    bit m_activo = 1'b0;
    int m_n      = 0;
    bit m_ocle   = 1'b0;
    int m_fase   = F_REPOSO;
    int m_ticks  = 0;
    int m_pulsos = 0;
    int m_cuenta = 0;

    secuenciador_medicion #(
        .DIV_CLE       (DIV),
        .ESPERA_TICKS  (ESP),
        .VENTANA_TICKS (VEN),
        .CNT_W         (W)
    ) dut (
        .iclk          (iclk),
        .ireset        (ireset),
        .ipulso_inicio (ipulso_inicio),
        .ipulso_sensor (ipulso_sensor),
        .ilisto_tx     (ilisto_tx),
        .ocle          (ocle),
        .ocuenta       (ocuenta),
        .ovalido       (ovalido),
        .omidiendo     (omidiendo),
        .oocupado      (oocupado)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string nombre, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nombre, act, exp_v, ciclo);
        end
    endtask

    // Model: ocle every DIV cycles since reset; phases advance on counted ticks
    always @(posedge iclk) begin
        bit tick;
        ciclo++;
        if (ireset) begin
            m_activo = 1'b1;
            m_n      = 0;
            m_ocle   = 1'b0;
            m_fase   = F_REPOSO;
            m_ticks  = 0;
            m_pulsos = 0;
            m_cuenta = 0;
        end else begin
            tick = m_ocle;
            case (m_fase)
                F_REPOSO: begin
                    if (ipulso_inicio) begin
                        m_fase   = F_ESPERA;
                        m_ticks  = 0;
                        m_pulsos = 0;
                        m_cuenta = 0;
                    end
                end
                F_ESPERA: begin
                    if (ABORTO && ipulso_inicio) begin
                        m_fase   = F_REPOSO;
                        m_cuenta = 0;
                    end else if (tick) begin
                        m_ticks++;
                        if (m_ticks == ESP) begin
                            m_fase  = F_MIDIENDO;
                            m_ticks = 0;
                        end
                    end
                end
                F_MIDIENDO: begin
                    if (ABORTO && ipulso_inicio) begin
                        m_fase   = F_REPOSO;
                        m_cuenta = 0;
                    end else begin
                        if (ipulso_sensor) m_pulsos++;
                        if (tick) begin
                            m_ticks++;
                            if (m_ticks == VEN) begin
                                m_fase   = F_ENTREGA;
                                m_cuenta = (m_pulsos > MAXC) ? MAXC : m_pulsos;
                            end
                        end
                    end
                end
                F_ENTREGA: begin
                    if (ilisto_tx) m_fase = F_REPOSO;
                end
                default: m_fase = F_REPOSO;
            endcase
            m_n++;
            m_ocle = ((m_n % DIV) == 0);
        end
    end

    // Per-cycle comparison against the model
    always @(posedge iclk) begin
        #1;
        if (m_activo) begin
            chk("ocle", int'(ocle), int'(m_ocle));
            chk("ocuenta", int'(ocuenta), m_cuenta);
            chk("ovalido", int'(ovalido), int'(m_fase == F_ENTREGA));
            chk("omidiendo", int'(omidiendo), int'(m_fase == F_MIDIENDO));
            chk("oocupado", int'(oocupado), int'(m_fase != F_REPOSO));
        end
    end

    task automatic ciclos(input int n);
        repeat (n) @(negedge iclk);
    endtask

    task automatic pulso_inicio();
        ipulso_inicio = 1'b1;
        @(negedge iclk);
        ipulso_inicio = 1'b0;
    endtask

    task automatic pulsos_sensor(input int n);
        for (int i = 0; i < n; i++) begin
            ipulso_sensor = 1'b1;
            @(negedge iclk);
            ipulso_sensor = 1'b0;
            @(negedge iclk);
        end
    endtask

    // Bounded wait: cual=0 waits for omidiendo, cual=1 for ovalido
    task automatic esperar(input bit cual, input string nombre);
        int lim;
        lim = 0;
        while ((((cual == 1'b0) ? omidiendo : ovalido) !== 1'b1) && (lim < 200)) begin
            @(negedge iclk);
            lim++;
        end
        if (lim >= 200) chk({nombre, " timeout"}, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        int n;
        bit visto;

        // Reset state
        ciclos(3);
        chk("reset ocle", int'(ocle), 0);
        chk("reset ocuenta", int'(ocuenta), 0);
        chk("reset ovalido", int'(ovalido), 0);
        chk("reset omidiendo", int'(omidiendo), 0);
        chk("reset oocupado", int'(oocupado), 0);

        // 1: idle after reset, ocle on cycles 4, 8, 12
        ireset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge iclk);
            chk("t1 ocle", int'(ocle), int'((k % 4) == 0));
            chk("t1 oocupado", int'(oocupado), 0);
        end

        // 2: five pulses, ready held high
        ilisto_tx = 1'b1;
        pulso_inicio();
        n = 0;
        while (ocle !== 1'b1 && n < 20) begin
            @(negedge iclk);
            n++;
        end
        c0 = ciclo;
        esperar(1'b0, "t2 midiendo");
        pulsos_sensor(5);
        esperar(1'b1, "t2 valido");
        c1 = ciclo;
        chk("t2 latency", c1 - c0, 37);
        chk("t2 ocuenta", int'(ocuenta), 5);
        @(negedge iclk);
        chk("t2 ovalido one cycle", int'(ovalido), 0);
        chk("t2 oocupado", int'(oocupado), 0);

        // 3: saturation and stalled handshake
        ilisto_tx = 1'b0;
        pulso_inicio();
        esperar(1'b0, "t3 midiendo");
        ipulso_sensor = 1'b1;
        ciclos(20);
        ipulso_sensor = 1'b0;
        esperar(1'b1, "t3 valido");
        chk("t3 ocuenta sat", int'(ocuenta), 15);
        for (int i = 0; i < 9; i++) begin
            @(negedge iclk);
            chk("t3 stall ovalido", int'(ovalido), 1);
            chk("t3 stall ocuenta", int'(ocuenta), 15);
        end
        ilisto_tx = 1'b1;
        @(negedge iclk);
        ilisto_tx = 1'b0;
        chk("t3 ovalido after accept", int'(ovalido), 0);
        chk("t3 oocupado after accept", int'(oocupado), 0);
        chk("t3 ocuenta kept", int'(ocuenta), 15);

        // 4: only the pulse coincident with the last window tick counts
        pulso_inicio();
        pulsos_sensor(1);
        esperar(1'b0, "t4 midiendo");
        n = 0;
        while (n < 7 && omidiendo === 1'b1) begin
            @(negedge iclk);
            if (ocle === 1'b1) n++;
        end
        ciclos(4);
        chk("t4 final ocle", int'(ocle), 1);
        ipulso_sensor = 1'b1;
        @(negedge iclk);
        ipulso_sensor = 1'b0;
        chk("t4 entrega", int'(ovalido), 1);
        pulsos_sensor(1);
        chk("t4 ocuenta", int'(ocuenta), 1);
        ilisto_tx = 1'b1;
        @(negedge iclk);
        ilisto_tx = 1'b0;
        chk("t4 ocuenta kept", int'(ocuenta), 1);

        // 5a: reset mid-window discards the count
        ilisto_tx = 1'b1;
        pulso_inicio();
        esperar(1'b0, "t5 midiendo");
        pulsos_sensor(3);
        ireset = 1'b1;
        @(negedge iclk);
        ireset = 1'b0;
        chk("t5 oocupado", int'(oocupado), 0);
        chk("t5 ocuenta", int'(ocuenta), 0);
        chk("t5 omidiendo", int'(omidiendo), 0);
        visto = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge iclk);
            if (ovalido === 1'b1) visto = 1'b1;
        end
        chk("t5 ovalido never", int'(visto), 0);

        // 5b: second start mid-window
        pulso_inicio();
        esperar(1'b0, "t5b midiendo");
        pulsos_sensor(3);
        pulso_inicio();
        pulsos_sensor(2);
`ifdef SECUENCIADOR_ABORTO_EN
        chk("t5b abort oocupado", int'(oocupado), 0);
        chk("t5b abort ocuenta", int'(ocuenta), 0);
        visto = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge iclk);
            if (ovalido === 1'b1) visto = 1'b1;
        end
        chk("t5b abort ovalido never", int'(visto), 0);
`else
        esperar(1'b1, "t5b valido");
        chk("t5b ocuenta", int'(ocuenta), 5);
`endif
        ciclos(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_medicion.md
Name: secuenciador_medicion

Overview:
Measurement sequencer for the spirometer front end.
- Generates the shared sample-enable tick that drives the `icle` input of every button and sensor edge-detector instance.
- Arms a measurement on a start-button pulse, waits a settle period, then counts turbine-sensor pulses over a fixed window.
- Hands the count to the serial/Bluetooth transmitter through a valid/ready handshake.

Parameters:
DIV_CLE, 50000, iclk cycles per ocle tick (≥2)
ESPERA_TICKS, 20, ocle ticks of settle time before the counting window (≥1)
VENTANA_TICKS, 1000, ocle ticks in the counting window (≥1)
CNT_W, 16, width of pulse counter/result

Ports:
iclk  in  1  system clock, single clock domain
ireset  in  1  synchronous reset, active-high
ipulso_inicio  in  1  one-cycle start pulse from button edge detector
ipulso_sensor  in  1  one-cycle turbine pulse from sensor edge detector
ilisto_tx  in  1  transmitter ready
ocle  out  1  one-cycle sample-enable tick for edge detectors
ocuenta  out  CNT_W  measured pulse count
ovalido  out  1  ocuenta valid, held until accepted
omidiendo  out  1  high while in MIDIENDO
oocupado  out  1  high in any state other than REPOSO

Behaviour:
- Reset is synchronous and active-high on posedge iclk. While ireset is high:
  - state = REPOSO; divider, tick counter and pulse counter = 0.
  - All outputs = 0, including ocuenta.
- Tick divider:
  - Free-running 0..DIV_CLE-1. ocle = 1 for exactly one cycle when the divider equals DIV_CLE-1.
  - First ocle occurs in cycle DIV_CLE after reset deasserts; the period is exactly DIV_CLE.
  - ocle runs in every state; it is independent of the FSM.
- FSM states: REPOSO, ESPERA, MIDIENDO, ENTREGA.
  - REPOSO: ipulso_inicio=1 -> ESPERA next cycle. On that transition the tick counter and pulse counter are cleared to 0, and ocuenta goes to 0.
  - ESPERA: tick counter increments on each ocle. The cycle on which the ESPERA_TICKS-th ocle occurs -> MIDIENDO next cycle, with the tick counter cleared.
  - MIDIENDO:
    - omidiendo = 1.
    - Each cycle with ipulso_sensor=1 increments the pulse counter.
    - Tick counter increments on ocle. The cycle of the VENTANA_TICKS-th ocle -> ENTREGA next cycle.
    - A sensor pulse coincident with that final ocle is counted.
    - Sensor pulses in any other state are ignored.
  - ENTREGA:
    - ocuenta = final count, registered; ovalido = 1.
    - ocuenta is stable while ovalido=1.
    - ovalido && ilisto_tx in the same cycle -> REPOSO next cycle, with ovalido = 0.
    - ocuenta keeps its value in REPOSO until the next start clears it.
- ilisto_tx is ignored outside ENTREGA.
- ipulso_inicio is ignored in ESPERA, MIDIENDO and ENTREGA; only REPOSO reacts to it (but see the optional feature below).
- Pulse counter saturates at 2^CNT_W-1; no wrap-around.
- Reset asserted in any state, including mid-window or mid-handshake: return to REPOSO next cycle. The partial count is discarded and ovalido drops.
- oocupado = (state != REPOSO). All outputs are registered.

Optional Feature:
Macro SECUENCIADOR_ABORTO_EN.
- Defined: ipulso_inicio=1 while in ESPERA or MIDIENDO aborts to REPOSO next cycle.
  - Pulse counter cleared; ocuenta = 0; no ENTREGA, ovalido stays 0.
  - A start pulse in ENTREGA is still ignored.
- Undefined: start pulses outside REPOSO are ignored, as in the base behaviour.

Test Plan:
(All scenarios use DIV_CLE=4, ESPERA_TICKS=2, VENTANA_TICKS=8, CNT_W=4.)
1. Release reset, no stimulus -> ocle high in cycles 4, 8, 12… only; all other outputs 0; state stays REPOSO.
2. Start pulse, then 5 sensor pulses inside the window, ilisto_tx=1 -> ovalido=1 for exactly 1 cycle with ocuenta=5. Cycles from the first ocle after start to ENTREGA match 2+8 ticks.
3. Start, then 20 sensor pulses in the window, ilisto_tx=0 for 10 cycles then 1 -> ocuenta=15 (saturated); ovalido and ocuenta stay stable for all 10 stalled cycles; REPOSO after acceptance.
4. Sensor pulse coincident with the 8th window ocle, plus one pulse in ESPERA and one in ENTREGA -> only the coincident pulse counted (ocuenta=1).
5. Start, 3 sensor pulses, ireset high for 1 cycle mid-window -> REPOSO, ocuenta=0, ovalido never asserts. A second start pulse mid-window without reset: macro undefined -> ignored, result delivered normally; macro defined -> abort, ocuenta=0, no ovalido.
